seq_lock_param: RTL



---
 rtl/seq_lock_param.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seq_lock_param.sv
// Parametrised serial-code lock: bits are entered one per strobe, MSB first.
// Repeated wrong bits trigger a timed lockout. An optional timeout relocks
// the lock automatically after it has been open for a set time.
module seq_lock_param #(
    parameter int unsigned           CODE_LEN       = 3,
    parameter logic [CODE_LEN-1:0]   CODE           = 3'b010,
    parameter int unsigned           MAX_TRIES      = 3,
    parameter int unsigned           LOCKOUT_CYCLES = 16,
    parameter int unsigned           AUTO_RELOCK    = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               code,
    input  logic                               code_valid,
    input  logic                               relock,
    output logic                               openlock,
    output logic                               alarm,
    output logic                               locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0]     fail_count,
    output logic [$clog2(CODE_LEN+1)-1:0]      progress
);

    localparam int unsigned FW   = $clog2(MAX_TRIES + 1);
    localparam int unsigned PW   = $clog2(CODE_LEN + 1);
    localparam int unsigned PAD  = 2 ** PW;
    localparam int unsigned TMAX = (LOCKOUT_CYCLES > AUTO_RELOCK) ? LOCKOUT_CYCLES : AUTO_RELOCK;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        S_ENTRY   = 2'd0,
        S_OPEN    = 2'd1,
        S_LOCKOUT = 2'd2
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [PAD-1:0]  code_rev;
    logic            exp_bit;
    logic [FW-1:0]   fail_next;

    // Code bits reordered so that progress indexes the next expected bit directly
    for (genvar g = 0; g < CODE_LEN; g++) begin : g_rev
        assign code_rev[g] = CODE[CODE_LEN-1-g];
    end
    if (PAD > CODE_LEN) begin : g_pad
        assign code_rev[PAD-1:CODE_LEN] = '0;
    end

    assign exp_bit   = code_rev[progress];
    assign fail_next = fail_count + FW'(1);

    // Lock state machine; every output is a register
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_ENTRY;
            timer      <= '0;
            openlock   <= 1'b0;
            alarm      <= 1'b0;
            locked_out <= 1'b0;
            fail_count <= '0;
            progress   <= '0;
        end else begin
            case (state)
                S_ENTRY: begin
                    alarm <= 1'b0;
                    if (relock) begin
                        progress <= '0;
                    end else if (code_valid) begin
                        if (code == exp_bit) begin
                            if (progress == PW'(CODE_LEN - 1)) begin
                                state      <= S_OPEN;
                                openlock   <= 1'b1;
                                progress   <= '0;
                                fail_count <= '0;
                                timer      <= '0;
                            end else begin
                                progress <= progress + PW'(1);
                            end
                        end else begin
                            // A wrong bit restarts entry; it is not reused as a first bit
                            progress   <= '0;
                            alarm      <= 1'b1;
                            fail_count <= fail_next;
                            if (fail_next == FW'(MAX_TRIES)) begin
                                state      <= S_LOCKOUT;
                                locked_out <= 1'b1;
                                timer      <= TW'(LOCKOUT_CYCLES);
                            end
                        end
                    end
                end
                S_OPEN: begin
                    if (relock || (AUTO_RELOCK != 0 && timer == TW'(AUTO_RELOCK - 1))) begin
                        state    <= S_ENTRY;
                        openlock <= 1'b0;
                        timer    <= '0;
                    end else if (AUTO_RELOCK != 0) begin
                        timer <= timer + TW'(1);
                    end
                end
                S_LOCKOUT: begin
                    if (timer == TW'(1)) begin
                        state      <= S_ENTRY;
                        locked_out <= 1'b0;
                        alarm      <= 1'b0;
                        fail_count <= '0;
                        progress   <= '0;
                        timer      <= '0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    state      <= S_ENTRY;
                    timer      <= '0;
                    openlock   <= 1'b0;
                    alarm      <= 1'b0;
                    locked_out <= 1'b0;
                    fail_count <= '0;
                    progress   <= '0;
                end
            endcase
        end
    end

endmodule
